// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] with K[0..63] via a 16-word sliding window.
// Define SHA256_SCHED_STALL_EN to honour ready_i backpressure; otherwise the stream runs one word per cycle.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [31:0]  w_o,
    output logic [31:0]  k_o,
    output logic [5:0]   round_o,
    output logic         first_o,
    output logic         last_o,
    output logic         busy_o
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      state_reg, state_next;
    logic [5:0]  t_reg, t_next;
    logic [31:0] win_reg  [16];
    logic [31:0] win_next [16];
    logic        ready_eff;
    logic        fire;
    logic        load;
    logic        advance;
    logic        at_last;
    logic [31:0] new_word;

`ifdef SHA256_SCHED_STALL_EN
    assign ready_eff = ready_i;
`else
    logic unused_ready;
    assign unused_ready = ready_i;
    assign ready_eff    = 1'b1;
`endif

    assign at_last  = (t_reg == 6'd63);
    assign fire     = (state_reg == RUN) & ready_eff;
    assign load     = blk_valid_i & blk_ready_o;
    assign advance  = fire & ~at_last;
    // Only the window feeds this adder; the result lands in win_reg[15], never on an output.
    assign new_word = sigma1(win_reg[14]) + win_reg[9] + sigma0(win_reg[1]) + win_reg[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            t_reg     <= 6'd0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        if (load) begin
            state_next = RUN;
            t_next     = 6'd0;
        end else if (advance) begin
            t_next = t_reg + 6'd1;
        end else if (fire) begin
            state_next = IDLE;
            t_next     = 6'd0;
        end
    end

    // Window: load from the block, shift on each emitted word, hold otherwise
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_win
            assign win_next[gi] = load    ? blk_i[511 - 32*gi -: 32] :
                                  advance ? win_reg[gi + 1] : win_reg[gi];
        end
    endgenerate
    assign win_next[15] = load ? blk_i[31:0] : advance ? new_word : win_reg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win_reg[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 16; i++) win_reg[i] <= win_next[i];
        end
    end

    // Output logic
    always_comb begin
        valid_o     = (state_reg == RUN);
        busy_o      = (state_reg == RUN);
        w_o         = win_reg[0];
        round_o     = t_reg;
        k_o         = valid_o ? K_ROM[t_reg] : 32'd0;
        first_o     = valid_o & (t_reg == 6'd0);
        last_o      = valid_o & at_last;
        blk_ready_o = (state_reg == IDLE) | (last_o & fire);
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: scoreboard of model W/K words plus table and hand-written corner sequences.
module tb_sha256_msg_schedule;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [511:0] blk_i;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [31:0]  w_o, k_o;
    logic [5:0]   round_o;
    logic         first_o, last_o, busy_o;

    sha256_msg_schedule dut (
        .clk(clk), .rst_n(rst_n), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
        .blk_i(blk_i), .valid_o(valid_o), .ready_i(ready_i), .w_o(w_o), .k_o(k_o),
        .round_o(round_o), .first_o(first_o), .last_o(last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct { logic [31:0] w; logic [31:0] k; logic [5:0] t; } exp_t;
    typedef struct { int t; logic [31:0] w; logic [31:0] k; logic first; logic last; bit use_model; } vec_t;

    exp_t        exp_q[$];
    logic [31:0] mw [64];
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];
    logic [1:0]  cap_fl [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          ready_mode = 0;
    int          stall_cnt  = 0;
    logic        rdy_eff;

`ifdef SHA256_SCHED_STALL_EN
    assign rdy_eff = ready_i;
`else
    assign rdy_eff = 1'b1;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Reference: full 64-word expansion, then queue one record per expected output word
    task automatic push_block(input logic [511:0] b);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            mw[t] = w[t];
            e.w = w[t]; e.k = K_TAB[t]; e.t = 6'(t);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: one comparison per emitted word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o && rdy_eff) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 128'(round_o), 128'hffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word", 128'({w_o, k_o, round_o, first_o, last_o}),
                    128'({e.w, e.k, e.t, e.t == 6'd0, e.t == 6'd63}));
                cap_w[round_o]  = w_o;
                cap_k[round_o]  = k_o;
                cap_fl[round_o] = {first_o, last_o};
            end
        end
    end

    // ready_i driver: 0 always ready, 1 random, 2 three-cycle stall at t = 20
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            ready_i = ($urandom_range(0, 3) != 0);
        end else if (ready_mode == 2 && stall_cnt < 3 && valid_o && round_o == 6'd20) begin
            ready_i = 1'b0;
            stall_cnt++;
        end else begin
            ready_i = 1'b1;
        end
        if (ready_mode != 2) stall_cnt = 0;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send_block(input logic [511:0] b);
        int n = 0;
        blk_i = b;
        blk_valid_i = 1'b1;
        @(negedge clk);
        while (!blk_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready_o) begin
            chk("accept_timeout", 128'(blk_ready_o), 128'(1));
        end else begin
            push_block(b);
            @(posedge clk);
            #1;
        end
        blk_valid_i = 1'b0;
        blk_i = rand_blk();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((exp_q.size() != 0 || busy_o) && n < 3000);
        chk({nm, "_drain"}, 128'({exp_q.size() == 0, busy_o}), 128'(2'b10));
    endtask

    vec_t         abc_tab [6];
    logic [511:0] abc_blk;
    logic [511:0] blk_a, blk_b;
    int           gaps, rdy_bad, n;

    initial begin
        abc_tab[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b1, 1'b0, 1'b0};
        abc_tab[1] = '{1,  32'h00000000, 32'h71374491, 1'b0, 1'b0, 1'b0};
        abc_tab[2] = '{15, 32'h00000018, 32'hc19bf174, 1'b0, 1'b0, 1'b0};
        abc_tab[3] = '{16, 32'h61626380, 32'he49b69c1, 1'b0, 1'b0, 1'b0};
        abc_tab[4] = '{17, 32'h000f0000, 32'hefbe4786, 1'b0, 1'b0, 1'b0};
        abc_tab[5] = '{63, 32'h00000000, 32'hc67178f2, 1'b0, 1'b1, 1'b1};
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;

        rst_n = 1'b0;
        blk_valid_i = 1'b0;
        blk_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({valid_o, w_o, k_o, round_o, first_o, last_o, busy_o, blk_ready_o}),
            128'({1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_release", 128'({blk_ready_o, busy_o}), 128'(2'b10));

        // "abc" block, then table of known words
        send_block(abc_blk);
        drain("abc");
        for (int i = 0; i < 6; i++) begin
            int t;
            t = abc_tab[i].t;
            chk($sformatf("abc_t%0d", t), 128'({cap_w[t], cap_k[t], cap_fl[t]}),
                128'({abc_tab[i].use_model ? mw[t] : abc_tab[i].w, abc_tab[i].k,
                      abc_tab[i].first, abc_tab[i].last}));
        end

        // Back-to-back: 128 consecutive words, ready pulse only on W[63]
        blk_a = rand_blk();
        blk_b = rand_blk();
        send_block(blk_a);
        blk_i = blk_b;
        blk_valid_i = 1'b1;
        gaps = 0;
        rdy_bad = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (!valid_o || round_o != 6'(i)) gaps++;
            if (i < 64 && blk_ready_o != (i == 63)) rdy_bad++;
            if (i == 63 && blk_ready_o) push_block(blk_b);
            @(posedge clk);
            #1;
            if (i == 63) blk_valid_i = 1'b0;
        end
        chk("b2b_gaps", 128'(gaps), 128'(0));
        chk("b2b_ready_pulse", 128'(rdy_bad), 128'(0));
        drain("b2b");

`ifdef SHA256_SCHED_STALL_EN
        // Stall three cycles at t = 20
        ready_mode = 2;
        send_block(rand_blk());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid_o && round_o == 6'd20) && n < 200);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("stall_hold%0d", s), 128'({ready_i, round_o, w_o, k_o}),
                128'({1'b0, 6'd20, mw[20], K_TAB[20]}));
            if (s < 2) @(negedge clk);
        end
        drain("stall");
        ready_mode = 0;
`endif

        // Asynchronous reset mid-block at t = 30
        send_block(rand_blk());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid_o && round_o == 6'd30) && n < 200);
        chk("reached_t30", 128'(round_o), 128'(6'd30));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midblock_reset", 128'({valid_o, w_o, k_o, round_o, first_o, last_o, busy_o, blk_ready_o}),
            128'({1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_block(rand_blk());
        chk("restart_t0", 128'({valid_o, round_o, first_o}), 128'({1'b1, 6'd0, 1'b1}));
        drain("after_reset");

        // Random blocks with random ready and junk on blk_i between blocks
        ready_mode = 1;
        for (int b = 0; b < 200; b++) begin
            repeat ($urandom_range(0, 2)) begin
                blk_i = rand_blk();
                @(posedge clk);
                #1;
            end
            send_block(rand_blk());
        end
        drain("random");
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
